// File: rtl/motion_bbox_detect_pkg.sv
// ---------------------------------------------------------------------------
// motion_bbox_detect_pkg
//   Shared image-geometry definitions for the motion-mask pipeline.
//   - Default frame geometry (IMG_W_DEF x IMG_H_DEF) and derived coordinate
//     and count widths.
//   - bbox_t: bounding-box record at the default geometry, the form in which
//     the overlay/display stage consumes a published box.
//   - state_t: states of the per-frame accumulation FSM.
//   - cnt_width(): width needed to count every pixel of a frame.
// ---------------------------------------------------------------------------
package motion_bbox_detect_pkg;

   localparam int IMG_W_DEF      = 640;
   localparam int IMG_H_DEF      = 480;
   localparam int MIN_PIXELS_DEF = 64;

   localparam int XW_DEF = $clog2(IMG_W_DEF);
   localparam int YW_DEF = $clog2(IMG_H_DEF);
   localparam int CW_DEF = $clog2(IMG_W_DEF * IMG_H_DEF + 1);

   typedef struct packed {
      logic [XW_DEF-1:0] x_min;
      logic [XW_DEF-1:0] x_max;
      logic [YW_DEF-1:0] y_min;
      logic [YW_DEF-1:0] y_max;
   } bbox_t;

   typedef enum logic {
      S_WAIT_SYNC = 1'b0,   // discarding the partial frame seen after reset
      S_ACTIVE    = 1'b1    // accumulating a complete frame
   } state_t;

   // Bits needed to hold a count of 0 .. w*h inclusive.
   function automatic int cnt_width(input int w, input int h);
      return $clog2(w * h + 1);
   endfunction

endpackage

// File: rtl/motion_bbox_detect_if.sv
// ---------------------------------------------------------------------------
// motion_bbox_detect_if
//   1-bit motion-mask pixel stream from the binarization stage.
//   bin_clken : pixel qualifier
//   bin_href  : line active, high during active pixels
//   bin_vsync : frame sync pulse, active-high, between frames
//   bin_bit   : motion-mask pixel, 1 = motion
//   master : stream producer (binarizer)
//   slave  : stream consumer (bounding-box detector, overlay stage)
// ---------------------------------------------------------------------------
interface motion_bbox_detect_if;

   logic bin_clken;
   logic bin_href;
   logic bin_vsync;
   logic bin_bit;

   modport master (
      output bin_clken,
      output bin_href,
      output bin_vsync,
      output bin_bit
   );

   modport slave (
      input bin_clken,
      input bin_href,
      input bin_vsync,
      input bin_bit
   );

endinterface

// File: rtl/motion_bbox_detect_pixel_xy_counter.sv
// ---------------------------------------------------------------------------
// pixel_xy_counter
//   Tracks the x/y position of the current pixel in a clken/href/vsync
//   stream. Shared between the bounding-box detector and the overlay stage.
//   Ports:
//     clk, rst_n : pixel clock, asynchronous active-low reset
//     clken      : pixel qualifier
//     href       : line active
//     vsync      : frame sync, active-high
//     x, y       : position of the pixel presented this cycle
//     vs_rise    : first cycle of vsync high (combinational)
//     in_range   : x < IMG_W and y < IMG_H
// ---------------------------------------------------------------------------
module pixel_xy_counter #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int XW    = $clog2(IMG_W),
   parameter int YW    = $clog2(IMG_H)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clken,
   input  logic          href,
   input  logic          vsync,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          vs_rise,
   output logic          in_range
);

   // The counters must be able to hold IMG_W / IMG_H themselves so that
   // saturation marks "past the active area" distinctly from the last pixel.
   localparam int XCW = $clog2(IMG_W + 1);
   localparam int YCW = $clog2(IMG_H + 1);

   localparam logic [XCW-1:0] X_LIM = XCW'(IMG_W);
   localparam logic [YCW-1:0] Y_LIM = YCW'(IMG_H);

   logic           href_q,  href_d;
   logic           vsync_q, vsync_d;
   logic [XCW-1:0] x_q,     x_d;
   logic [YCW-1:0] y_q,     y_d;
   logic           hr_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         href_q  <= 1'b0;
         vsync_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         href_q  <= href_d;
         vsync_q <= vsync_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      href_d  = href;
      vsync_d = vsync;
      vs_rise = vsync & ~vsync_q;
      hr_fall = ~href & href_q;

      x_d = x_q;
      if (vs_rise || hr_fall) begin
         x_d = '0;
      end else if (clken && href && (x_q != X_LIM)) begin
         x_d = x_q + 1'b1;
      end

      // A line only advances y if it actually carried pixels, so stray
      // href blips with no clken do not shift the frame.
      y_d = y_q;
      if (vs_rise) begin
         y_d = '0;
      end else if (hr_fall && (x_q != '0) && (y_q != Y_LIM)) begin
         y_d = y_q + 1'b1;
      end
   end

   assign in_range = (x_q < X_LIM) && (y_q < Y_LIM);
   // Truncation only loses information when in_range is low.
   assign x        = x_q[XW-1:0];
   assign y        = y_q[YW-1:0];

endmodule

// File: rtl/motion_bbox_detect.sv
// ---------------------------------------------------------------------------
// motion_bbox_detect
//   Accumulates, per frame, the bounding box and count of motion pixels in a
//   1-bit motion-mask stream and publishes them at each frame boundary.
//   Ports:
//     clk, rst_n  : pixel clock, asynchronous active-low reset
//     bin         : motion-mask stream (slave modport)
//     frame_done  : one-cycle pulse, results updated this cycle
//     box_valid   : motion count >= MIN_PIXELS in the last frame
//     box_x_min/box_x_max/box_y_min/box_y_max : inclusive box edges
//     motion_cnt  : motion pixels in the last frame, saturating
//   Results are published on the first clock at which bin_vsync is sampled
//   high and then held until the next frame boundary. The frame in progress
//   at reset release is discarded.
// ---------------------------------------------------------------------------
module motion_bbox_detect
   import motion_bbox_detect_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int MIN_PIXELS = MIN_PIXELS_DEF,
   parameter int XW         = $clog2(IMG_W),
   parameter int YW         = $clog2(IMG_H),
   parameter int CW         = cnt_width(IMG_W, IMG_H)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   motion_bbox_detect_if.slave  bin,
   output logic                 frame_done,
   output logic                 box_valid,
   output logic [XW-1:0]        box_x_min,
   output logic [XW-1:0]        box_x_max,
   output logic [YW-1:0]        box_y_min,
   output logic [YW-1:0]        box_y_max,
   output logic [CW-1:0]        motion_cnt
);

   typedef struct packed {
      logic [XW-1:0] x_min;
      logic [XW-1:0] x_max;
      logic [YW-1:0] y_min;
      logic [YW-1:0] y_max;
   } box_t;

   localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);
   localparam logic [CW-1:0] CNT_MAX = '1;

   // Start with an inverted box so the first motion pixel sets all edges.
   localparam box_t BOX_INIT = '{
      x_min: XW'(IMG_W - 1),
      x_max: '0,
      y_min: YW'(IMG_H - 1),
      y_max: '0
   };

   // ---------------------------------------------------------------------
   // Position tracking
   // ---------------------------------------------------------------------
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic          vs_rise;
   logic          in_range;
   logic          acc;

   pixel_xy_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .XW    (XW),
      .YW    (YW)
   ) u_xy (
      .clk      (clk),
      .rst_n    (rst_n),
      .clken    (bin.bin_clken),
      .href     (bin.bin_href),
      .vsync    (bin.bin_vsync),
      .x        (pix_x),
      .y        (pix_y),
      .vs_rise  (vs_rise),
      .in_range (in_range)
   );

   assign acc = bin.bin_clken & bin.bin_href & ~bin.bin_vsync & in_range;

   // ---------------------------------------------------------------------
   // State, accumulators and published results
   // ---------------------------------------------------------------------
   state_t        state_q,      state_d;
   box_t          acc_box_q,    acc_box_d;
   logic [CW-1:0] acc_cnt_q,    acc_cnt_d;
   box_t          out_box_q,    out_box_d;
   logic [CW-1:0] out_cnt_q,    out_cnt_d;
   logic          out_valid_q,  out_valid_d;
   logic          frame_done_q, frame_done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_WAIT_SYNC;
         acc_box_q    <= '0;
         acc_cnt_q    <= '0;
         out_box_q    <= '0;
         out_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_box_q    <= acc_box_d;
         acc_cnt_q    <= acc_cnt_d;
         out_box_q    <= out_box_d;
         out_cnt_q    <= out_cnt_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_box_d    = acc_box_q;
      acc_cnt_d    = acc_cnt_q;
      out_box_d    = out_box_q;
      out_cnt_d    = out_cnt_q;
      out_valid_d  = out_valid_q;
      frame_done_d = 1'b0;

      unique case (state_q)
         S_WAIT_SYNC: begin
            if (vs_rise) begin
               state_d   = S_ACTIVE;
               acc_box_d = BOX_INIT;
               acc_cnt_d = '0;
            end
         end

         S_ACTIVE: begin
            // acc already excludes vsync-high cycles, so the two branches
            // can never both apply in one cycle.
            if (vs_rise) begin
               // An empty frame publishes a zero box rather than the
               // inverted initial box.
               out_box_d    = (acc_cnt_q == '0) ? box_t'('0) : acc_box_q;
               out_cnt_d    = acc_cnt_q;
               out_valid_d  = (acc_cnt_q >= MIN_CNT);
               frame_done_d = 1'b1;
               acc_box_d    = BOX_INIT;
               acc_cnt_d    = '0;
            end else if (acc && bin.bin_bit) begin
               if (pix_x < acc_box_q.x_min) acc_box_d.x_min = pix_x;
               if (pix_x > acc_box_q.x_max) acc_box_d.x_max = pix_x;
               if (pix_y < acc_box_q.y_min) acc_box_d.y_min = pix_y;
               if (pix_y > acc_box_q.y_max) acc_box_d.y_max = pix_y;
               if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_WAIT_SYNC;
         end
      endcase
   end

   assign frame_done = frame_done_q;
   assign box_valid  = out_valid_q;
   assign box_x_min  = out_box_q.x_min;
   assign box_x_max  = out_box_q.x_max;
   assign box_y_min  = out_box_q.y_min;
   assign box_y_max  = out_box_q.y_max;
   assign motion_cnt = out_cnt_q;

endmodule
